pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single physical-memory port between the instruction cache and the data cache.
//  - Each cache controller issues whole-line read (allocate) or write (write-back) requests.
//  - Grants one requester at a time and latches its command into the pmem port.
//  - Routes pmem_resp/pmem_rdata back to the granted requester.
//  - Sits between both cache_control/datapath pairs and main memory.
// PARAMETERS
//  ADDR_W  32   physical address width
//  LINE_W  256  cache line width (bits per pmem transfer)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  i_read       in   1       I-cache line read request; held until i_resp
//  i_write      in   1       I-cache line write request; held until i_resp
//  i_address    in   ADDR_W  I-cache line address; stable while requesting
//  i_wdata      in   LINE_W  I-cache write line
//  i_rdata      out  LINE_W  read line to I-cache
//  i_resp       out  1       I-cache transaction complete (1-cycle pulse)
//  d_read/d_write/d_address/d_wdata/d_rdata/d_resp   same roles for D-cache
//  pmem_read    out  1       memory read strobe, held until pmem_resp
//  pmem_write   out  1       memory write strobe, held until pmem_resp
//  pmem_address out  ADDR_W  memory line address
//  pmem_wdata   out  LINE_W  memory write line
//  pmem_rdata   in   LINE_W  memory read line, valid with pmem_resp
//  pmem_resp    in   1       memory transaction complete
// BEHAVIOUR
//  - Reset: state=IDLE; pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp and d_resp all 0.
//  - Request definitions: req_i = i_read|i_write; req_d = d_read|d_write.
//  - FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
//  - IDLE:
//    - With req_d|req_i, picks a winner per the tie rule.
//    - On the clock edge, registers the winner's address, wdata and op into pmem_address,
//      pmem_wdata and pmem_read/pmem_write, and moves to GRANT_x.
//    - No request: stays in IDLE with all strobes 0.
//  - Tie rule (both requesting in IDLE): D-cache wins (fixed priority), unless ARB_RR_EN.
//  - Read and write asserted together by one requester: treated as write (pmem_write=1, pmem_read=0).
//  - GRANT_x:
//    - pmem strobe, address and wdata stay at their latched values. Requester changes are ignored.
//    - A requester dropping its request mid-grant does not abort; the transaction completes.
//    - On pmem_resp=1, x_resp=1 combinationally in the same cycle, then next state = RELEASE.
//  - RELEASE:
//    - pmem_read=pmem_write=0 and no grant.
//    - Exactly 1 cycle, so the requester can drop its request; then IDLE.
//  - i_rdata = d_rdata = pmem_rdata (unregistered). The unselected x_resp is always 0.
//  - Latency:
//    - Request seen in IDLE at cycle N: pmem strobe at N+1.
//    - x_resp in the same cycle as pmem_resp.
//    - Minimum back-to-back grant spacing: pmem_resp cycle + RELEASE + IDLE.
//  - pmem_resp in IDLE or RELEASE: ignored, no x_resp.
//  - Reset mid-grant: next cycle is IDLE with outputs at reset values, and the pending x_resp is
//    never issued. pmem is reset by the same rst.
// CONFIGURATION
//  ARB_RR_EN defined:
//    - 1-bit last_grant register (reset value = I), so the D-cache wins the first tie.
//    - On a tie, grants the requester not in last_grant.
//    - last_grant updates on every entry into GRANT_x.
//  ARB_RR_EN undefined:
//    - D-cache always wins ties; no last_grant register.
//    - The I-cache may wait while the D-cache streams requests.
// TESTING
//  1. i_read=1, i_address=0x0000_1000; pmem_resp 3 cycles later, pmem_rdata=0xA5..A5
//     -> pmem_read=1 with addr 0x1000 from the next cycle, i_resp=1 and i_rdata=0xA5..A5 for
//     1 cycle, d_resp=0.
//  2. d_write=1, d_address=0x0000_2040, d_wdata=0x1234..; pmem_resp after 2 cycles
//     -> pmem_write=1, pmem_wdata=0x1234.., d_resp 1 pulse, RELEASE with strobes 0.
//  3. i_read and d_read asserted the same cycle
//     -> D-cache granted first (0x2040), I-cache granted after RELEASE+IDLE.
//     With ARB_RR_EN, a second simultaneous pair grants the I-cache first.
//  4. During GRANT_D change d_address to 0x3000 and drop d_write
//     -> pmem_address stays 0x2040, pmem_write stays 1, d_resp still pulses on pmem_resp.
//  5. Assert rst the cycle after the grant
//     -> next cycle pmem_read=pmem_write=0, no i_resp/d_resp; a fresh i_read is granted normally.
//  6. Spurious pmem_resp=1 in IDLE with no requests
//     -> i_resp=d_resp=0, state stays IDLE.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Two-way arbiter sharing one physical-memory line port between the I-cache and D-cache.
// Optional round-robin tie-break is enabled by defining ARB_RR_EN (default: D-cache fixed priority).
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } cmd_t;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  cmd_t   i_cmd, d_cmd, win_cmd;
  logic   req_i, req_d, pick_d;

  // Read+write together from one requester is issued as a write.
  assign i_cmd = '{rd: i_read & ~i_write, wr: i_write, addr: i_address, wdata: i_wdata};
  assign d_cmd = '{rd: d_read & ~d_write, wr: d_write, addr: d_address, wdata: d_wdata};
  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

`ifdef ARB_RR_EN
  // last_d_q: 1 = D-cache held the most recent grant; resets to I so D wins the first tie.
  logic last_d_q, last_d_d;
  assign pick_d = req_d & (~req_i | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (req_i || req_d)) last_d_d = pick_d;
  end

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  assign pick_d = req_d;
`endif

  assign win_cmd = pick_d ? d_cmd : i_cmd;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          cmd_d   = win_cmd;
          state_d = pick_d ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          i_resp   = (state_q == GRANT_I) & ~rst;
          d_resp   = (state_q == GRANT_D) & ~rst;
          cmd_d.rd = 1'b0;
          cmd_d.wr = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  assign pmem_read    = cmd_q.rd;
  assign pmem_write   = cmd_q.wr;
  assign pmem_address = cmd_q.addr;
  assign pmem_wdata   = cmd_q.wdata;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: cycle table from reset plus hand sequences for
// mid-grant requester changes and reset during a grant.
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk = 1'b0, rst = 1'b1;
  logic i_read = 0, i_write = 0, d_read = 0, d_write = 0, pmem_resp = 0;
  logic [ADDR_W-1:0] i_address = 32'h0000_1000, d_address = 32'h0000_2040;
  logic [LINE_W-1:0] i_wdata = {32{8'h5A}}, d_wdata = {16{16'h1234}};
  logic [LINE_W-1:0] pmem_rdata = {32{8'hA5}};
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;

  int n_chk = 0, n_fail = 0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir, iw, dr, dw, presp;
    logic er, ew, eir, edr;
    logic acare;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ewd;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] in, input logic [3:0] ex, input logic acare,
                              input logic [ADDR_W-1:0] ea, input logic [LINE_W-1:0] ewd);
    vec_t v;
    {v.ir, v.iw, v.dr, v.dw, v.presp} = in;
    {v.er, v.ew, v.eir, v.edr} = ex;
    v.acare = acare; v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  task automatic tick_drive();
    @(negedge clk);
  endtask

  initial begin
    logic [LINE_W-1:0] IW, DW, RD;
    logic got;
    IW = {32{8'h5A}}; DW = {16{16'h1234}}; RD = {32{8'hA5}};
    // inputs {ir,iw,dr,dw,presp}; expected {pmem_read,pmem_write,i_resp,d_resp}
    tbl[0]  = mk(5'b00001, 4'b0000, 0, '0, '0);        // spurious resp in IDLE
    tbl[1]  = mk(5'b10000, 4'b0000, 0, '0, '0);
    tbl[2]  = mk(5'b10000, 4'b1000, 1, 32'h1000, IW);
    tbl[3]  = mk(5'b10000, 4'b1000, 1, 32'h1000, IW);
    tbl[4]  = mk(5'b10001, 4'b1010, 1, 32'h1000, IW);
    tbl[5]  = mk(5'b00001, 4'b0000, 0, '0, '0);        // resp in RELEASE ignored
    tbl[6]  = mk(5'b00010, 4'b0000, 0, '0, '0);
    tbl[7]  = mk(5'b00010, 4'b0100, 1, 32'h2040, DW);
    tbl[8]  = mk(5'b00011, 4'b0101, 1, 32'h2040, DW);
    tbl[9]  = mk(5'b00000, 4'b0000, 0, '0, '0);
    tbl[10] = mk(5'b10100, 4'b0000, 0, '0, '0);        // tie, last grant was D
`ifdef ARB_RR_EN
    tbl[11] = mk(5'b10101, 4'b1010, 1, 32'h1000, IW);
`else
    tbl[11] = mk(5'b10101, 4'b1001, 1, 32'h2040, DW);
`endif
    tbl[12] = mk(5'b10100, 4'b0000, 0, '0, '0);
    tbl[13] = mk(5'b10100, 4'b0000, 0, '0, '0);        // tie again: D wins in both modes
    tbl[14] = mk(5'b10101, 4'b1001, 1, 32'h2040, DW);
    tbl[15] = mk(5'b00000, 4'b0000, 0, '0, '0);
    tbl[16] = mk(5'b11000, 4'b0000, 0, '0, '0);        // read+write -> write
    tbl[17] = mk(5'b11001, 4'b0110, 1, 32'h1000, IW);
    tbl[18] = mk(5'b00000, 4'b0000, 0, '0, '0);
    tbl[19] = mk(5'b00000, 4'b0000, 0, '0, '0);

    repeat (3) @(negedge clk);
    #1 chk("reset_state", {pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata},
           '0);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      {i_read, i_write, d_read, d_write, pmem_resp} =
        {tbl[k].ir, tbl[k].iw, tbl[k].dr, tbl[k].dw, tbl[k].presp};
      #1;
      chk($sformatf("row%0d_ctl", k), {pmem_read, pmem_write, i_resp, d_resp},
          {tbl[k].er, tbl[k].ew, tbl[k].eir, tbl[k].edr});
      if (tbl[k].acare)
        chk($sformatf("row%0d_cmd", k), {pmem_address, pmem_wdata}, {tbl[k].ea, tbl[k].ewd});
      if (tbl[k].presp)
        chk($sformatf("row%0d_rdata", k), {i_rdata, d_rdata}, {RD, RD});
    end

    // Requester changes and drops mid-grant; transaction still completes.
    @(negedge clk);
    {i_read, i_write, d_read, d_write, pmem_resp} = 5'b00010;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk); #1;
      got = pmem_write;
    end
    chk("hold_grant_seen", {299'b0, got}, 300'b1);
    d_address = 32'h0000_3000; d_write = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk($sformatf("hold_cyc%0d", c), {pmem_write, pmem_read, pmem_address},
          {1'b1, 1'b0, 32'h2040});
    end
    @(negedge clk); pmem_resp = 1'b1; #1;
    chk("hold_resp", {d_resp, i_resp}, 2'b10);
    @(negedge clk); pmem_resp = 1'b0; d_address = 32'h0000_2040;
    #1 chk("hold_release", {pmem_read, pmem_write, d_resp}, 3'b000);
    @(negedge clk);

    // Reset the cycle after the grant; the pending response is dropped.
    @(negedge clk); i_read = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_granted", {pmem_read, pmem_address}, {1'b1, 32'h1000});
    @(negedge clk); rst = 1'b0; i_read = 1'b0; pmem_resp = 1'b1; #1;
    chk("rst_cleared", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    @(negedge clk); pmem_resp = 1'b0; i_read = 1'b1; #1;
    chk("rst_idle", {pmem_read, pmem_write}, 2'b00);
    @(negedge clk); #1;
    chk("rst_regrant", {pmem_read, pmem_write, pmem_address}, {2'b10, 32'h1000});
    @(negedge clk); pmem_resp = 1'b1; #1;
    chk("rst_regrant_resp", {i_resp, d_resp, i_rdata}, {2'b10, RD});
    @(negedge clk); pmem_resp = 1'b0; i_read = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
